// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter:
//   - arb_state_t     : arbiter FSM state encoding (IDLE / BURST)
//   - STALL_CNT_WIDTH : width of the saturating backpressure counter
//   - clog2()         : ceiling log2, used to size the per-grant beat counter
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_WIDTH = 16;

    // Ceiling log2; clog2(1) is 0 so a BURST_LEN of 1 still gets a 1-bit counter
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = ((32'sd1 << i) < value) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search. Looks for the first set request starting
// at the producer after i_last_grant and wrapping around.
// Ports:
//   i_req        : per-producer request vector
//   i_last_grant : index of the previous winner
//   o_found      : at least one request is set
//   o_winner     : index of the selected producer (valid when o_found)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last_grant,
    output logic                 o_found,
    output logic [IDX_WIDTH-1:0] o_winner
);

    // One spare bit so origin + offset never overflows before the wrap
    localparam logic [IDX_WIDTH:0] LAST_IDX  = (IDX_WIDTH+1)'(NUM_REQ - 1);
    localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);

    logic [IDX_WIDTH:0]   w_start;
    logic [IDX_WIDTH:0]   w_offset;
    logic [IDX_WIDTH:0]   w_sum;
    logic [2*NUM_REQ-1:0] w_doubled;
    logic [NUM_REQ-1:0]   w_rotated;

    // Search origin: the producer after the last winner, wrapping at NUM_REQ
    always_comb begin
        if ({1'b0, i_last_grant} >= LAST_IDX) begin
            w_start = '0;
        end else begin
            w_start = {1'b0, i_last_grant} + (IDX_WIDTH+1)'(1);
        end
    end

    // Rotating a doubled copy brings the origin to bit 0
    assign w_doubled = {i_req, i_req};
    assign w_rotated = w_doubled[w_start +: NUM_REQ];
    assign o_found   = |w_rotated;

    // Lowest set bit of the rotated vector is the nearest requester after the origin
    always_comb begin
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_offset = w_rotated[i] ? (IDX_WIDTH+1)'(i) : w_offset;
        end
    end

    // Undo the rotation: origin + offset, modulo NUM_REQ
    always_comb begin
        w_sum = w_start + w_offset;
        if (w_sum >= NUM_REQ_W) begin
            o_winner = IDX_WIDTH'(w_sum - NUM_REQ_W);
        end else begin
            o_winner = w_sum[IDX_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// producers. A winner owns the port for up to BURST_LEN accepted writes;
// arbitration takes one IDLE cycle. Backpressure cycles are counted.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   req, req_data      : per-producer request and packed write data
//   ack                : one-hot, the owner's write was accepted this cycle
//   fifo_full          : FIFO backpressure
//   fifo_write_enable  : FIFO write strobe
//   fifo_write_data    : FIFO write data (owner's slice in BURST, 0 in IDLE)
//   grant_valid        : a producer currently owns the port
//   grant_id           : current or last owner
//   stall_count        : saturating count of backpressure cycles
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_write_enable,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic                          grant_valid,
    output logic [IDX_WIDTH-1:0]          grant_id,
    output logic [STALL_CNT_WIDTH-1:0]    stall_count
);

    localparam int                    BEAT_WIDTH = clog2(BURST_LEN) + 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(BURST_LEN - 1);

    arb_state_t                 r_state;
    logic [IDX_WIDTH-1:0]       r_owner;
    logic [IDX_WIDTH-1:0]       r_last_grant;
    logic [BEAT_WIDTH-1:0]      r_beat_cnt;
    logic [STALL_CNT_WIDTH-1:0] r_stall_count;

    logic                       w_found;
    logic [IDX_WIDTH-1:0]       w_winner;
    logic                       w_owner_req;
    logic                       w_write;
    logic [DATA_WIDTH-1:0]      w_slices [NUM_REQ];

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_picker (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_winner     (w_winner)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slices[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Outputs derive from r_state, so an asynchronous reset silences them at once
    assign w_owner_req       = req[r_owner];
    assign w_write           = (r_state == ST_BURST) && w_owner_req && !fifo_full;
    assign fifo_write_enable = w_write;
    assign grant_valid       = (r_state == ST_BURST);
    assign grant_id          = r_owner;
    assign stall_count       = r_stall_count;

    // Acknowledge only the owner, and only on an accepted write
    always_comb begin
        ack = '0;
        if (w_write) begin
            ack[r_owner] = 1'b1;
        end else begin
            ack = '0;
        end
    end

    // Owner's data is presented throughout the burst, even while stalled
    always_comb begin
        if (r_state == ST_BURST) begin
            fifo_write_data = w_slices[r_owner];
        end else begin
            fifo_write_data = '0;
        end
    end

    // Arbitration FSM, beat counting and backpressure counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_last_grant  <= IDX_WIDTH'(NUM_REQ - 1);
            r_beat_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!w_owner_req) begin
                        // Producer withdrew: release the port without writing
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_owner;
                    end else if (fifo_full) begin
                        // Stall keeps ownership and beat position
                        if (r_stall_count != {STALL_CNT_WIDTH{1'b1}}) begin
                            r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
                        end else begin
                            r_stall_count <= r_stall_count;
                        end
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_owner;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + BEAT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int BURST_LEN  = 4;
    localparam int IDX_WIDTH  = 2;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  id;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_write_enable;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          grant_valid;
    logic [IDX_WIDTH-1:0]          grant_id;
    logic [15:0]                   stall_count;

    int        n_checks = 0;
    int        n_errors = 0;
    sb_entry_t sb_q[$];
    int        wcnt[NUM_REQ];
    int        exp_cnt[NUM_REQ];
    sb_entry_t mon_exp;
    logic [NUM_REQ-1:0] mon_onehot;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .IDX_WIDTH  (IDX_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_data          (req_data),
        .ack               (ack),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id),
        .stall_count       (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every FIFO write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && fifo_write_enable === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_write: got id=%0d data=%h, required no write", grant_id, fifo_write_data);
            end else begin
                mon_exp = sb_q.pop_front();
                mon_onehot = '0;
                mon_onehot[mon_exp.id] = 1'b1;
                if (fifo_write_data !== mon_exp.data || grant_id !== mon_exp.id || ack !== mon_onehot) begin
                    n_errors++;
                    $display("FAIL sb_write: got id=%0d data=%h ack=%b, required id=%0d data=%h ack=%b",
                             grant_id, fifo_write_data, ack, mon_exp.id, mon_exp.data, mon_onehot);
                end
            end
        end
    end

    // Producer i presents {i, number of its writes accepted so far}
    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = {4'(i), 12'(wcnt[i])};
        end
    endtask

    task automatic push_write(input int p);
        sb_entry_t e;
        e.id   = IDX_WIDTH'(p);
        e.data = {4'(p), 12'(exp_cnt[p])};
        exp_cnt[p]++;
        sb_q.push_back(e);
    endtask

    // Called at a negedge: close the cycle, advance producers that were acked
    task automatic finish_cycle();
        logic [NUM_REQ-1:0] acked;
        acked = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acked[i]) wcnt[i]++;
        end
        drive_data();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d pending writes, required 0", name, sb_q.size());
            sb_q.delete();
        end
        finish_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        fifo_full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (ack !== 4'b0000 || fifo_write_enable !== 1'b0 || grant_valid !== 1'b0 ||
                grant_id !== 2'd0 || stall_count !== 16'h0000 || fifo_write_data !== 16'h0000) begin
                n_errors++;
                $display("FAIL reset_outputs: got ack=%b en=%b gv=%b gid=%0d stall=%0d data=%h, required all 0",
                         ack, fifo_write_enable, grant_valid, grant_id, stall_count, fifo_write_data);
            end
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant_valid !== 1'b0 || fifo_write_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got gv=%b en=%b, required 0 0", grant_valid, fifo_write_enable);
        end
        finish_cycle();
    endtask

    task automatic test_single_producer();
        logic [0:9] en_tab;
        en_tab = 10'b0111101111;
        req = 4'b0001;
        fifo_full = 1'b0;
        apply_reset();
        for (int p = 0; p < 8; p++) push_write(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_write_enable !== en_tab[c] || ack[0] !== en_tab[c] || grant_id !== 2'd0) begin
                n_errors++;
                $display("FAIL single_cycle%0d: got en=%b ack0=%b gid=%0d, required en=%b ack0=%b gid=0",
                         c + 1, fifo_write_enable, ack[0], grant_id, en_tab[c], en_tab[c]);
            end
            finish_cycle();
        end
        req = 4'b0000;
        check_drained("single");
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   exp_order[5];
        int   writes;
        int   first3;
        logic prev_gv;
        exp_order = '{0, 1, 2, 3, 0};
        writes = 0;
        first3 = 0;
        prev_gv = 1'b0;
        req = 4'b1111;
        fifo_full = 1'b0;
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < BURST_LEN; b++) push_write(exp_order[g]);
        end
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
                order.push_back(int'(grant_id));
                if (grant_id === 2'd3 && first3 == 0) first3 = c;
            end
            prev_gv = grant_valid;
            if (fifo_write_enable === 1'b1) writes++;
            finish_cycle();
        end
        req = 4'b0000;
        n_checks++;
        if (order.size() != 5) begin
            n_errors++;
            $display("FAIL rr_grant_count: got %0d grants, required 5", order.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                n_checks++;
                if (order[g] != exp_order[g]) begin
                    n_errors++;
                    $display("FAIL rr_order%0d: got producer %0d, required %0d", g, order[g], exp_order[g]);
                end
            end
        end
        n_checks++;
        if (writes != 20) begin
            n_errors++;
            $display("FAIL rr_writes: got %0d, required 20", writes);
        end
        n_checks++;
        if (first3 != 17) begin
            n_errors++;
            $display("FAIL rr_fairness: got producer 3 first granted in cycle %0d, required 17", first3);
        end
        check_drained("rr");
    endtask

    task automatic test_backpressure();
        logic [0:8] full_tab;
        logic [0:8] en_tab;
        logic [0:8] gv_tab;
        int         writes;
        full_tab = 9'b000111000;
        en_tab   = 9'b011000110;
        gv_tab   = 9'b011111110;
        writes = 0;
        req = 4'b0010;
        fifo_full = 1'b0;
        apply_reset();
        for (int p = 0; p < 4; p++) push_write(1);
        for (int c = 0; c < 9; c++) begin
            req = (c == 8) ? 4'b0000 : 4'b0010;
            fifo_full = full_tab[c];
            @(negedge clk);
            n_checks++;
            if (fifo_write_enable !== en_tab[c] || ack[1] !== en_tab[c] || grant_valid !== gv_tab[c]) begin
                n_errors++;
                $display("FAIL stall_cycle%0d: got en=%b ack1=%b gv=%b, required en=%b ack1=%b gv=%b",
                         c + 1, fifo_write_enable, ack[1], grant_valid, en_tab[c], en_tab[c], gv_tab[c]);
            end
            if (ack[1] === 1'b1) writes++;
            finish_cycle();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_count !== 16'd3) begin
            n_errors++;
            $display("FAIL stall_count: got %0d, required 3", stall_count);
        end
        n_checks++;
        if (writes != 4) begin
            n_errors++;
            $display("FAIL stall_writes: got %0d, required 4", writes);
        end
        finish_cycle();
        check_drained("stall");
    endtask

    task automatic test_withdraw();
        logic [3:0] req_tab [9];
        logic [1:0] gid_tab [9];
        logic [0:8] en_tab;
        logic [0:8] gv_tab;
        req_tab = '{4'b0100, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        gid_tab = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        en_tab  = 9'b010011110;
        gv_tab  = 9'b011011110;
        req = req_tab[0];
        fifo_full = 1'b0;
        apply_reset();
        push_write(2);
        for (int p = 0; p < 4; p++) push_write(0);
        for (int c = 0; c < 9; c++) begin
            req = req_tab[c];
            @(negedge clk);
            n_checks++;
            if (fifo_write_enable !== en_tab[c] || grant_valid !== gv_tab[c] || grant_id !== gid_tab[c]) begin
                n_errors++;
                $display("FAIL withdraw_cycle%0d: got en=%b gv=%b gid=%0d, required en=%b gv=%b gid=%0d",
                         c + 1, fifo_write_enable, grant_valid, grant_id, en_tab[c], gv_tab[c], gid_tab[c]);
            end
            finish_cycle();
        end
        check_drained("withdraw");
    endtask

    task automatic test_reset_mid_burst();
        logic [0:4] en_tab;
        en_tab = 5'b01111;
        req = 4'b1000;
        fifo_full = 1'b0;
        apply_reset();
        push_write(3);
        push_write(3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            finish_cycle();
        end
        // Third beat of producer 3 is in progress; reset lands between edges
        #2;
        n_checks++;
        if (fifo_write_enable !== 1'b1 || grant_id !== 2'd3) begin
            n_errors++;
            $display("FAIL midrst_before: got en=%b gid=%0d, required en=1 gid=3", fifo_write_enable, grant_id);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ack !== 4'b0000 || fifo_write_enable !== 1'b0 || grant_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: got ack=%b en=%b gv=%b, required 0000 0 0", ack, fifo_write_enable, grant_valid);
        end
        req = 4'b1001;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 4; p++) push_write(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_write_enable !== en_tab[c] || grant_id !== 2'd0) begin
                n_errors++;
                $display("FAIL midrst_cycle%0d: got en=%b gid=%0d, required en=%b gid=0",
                         c + 1, fifo_write_enable, grant_id, en_tab[c]);
            end
            finish_cycle();
        end
        req = 4'b0000;
        check_drained("midrst");
    endtask

    task automatic test_stall_saturation();
        logic saw_write;
        logic lost_grant;
        saw_write = 1'b0;
        lost_grant = 1'b0;
        req = 4'b0001;
        fifo_full = 1'b1;
        apply_reset();
        for (int p = 0; p < 4; p++) push_write(0);
        @(negedge clk);
        finish_cycle();
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (fifo_write_enable !== 1'b0) saw_write = 1'b1;
            if (grant_valid !== 1'b1) lost_grant = 1'b1;
            if (k == 100) begin
                n_checks++;
                if (stall_count !== 16'd100) begin
                    n_errors++;
                    $display("FAIL sat_partial: got %0d, required 100", stall_count);
                end
            end
            finish_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (stall_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sat_count: got %h, required ffff", stall_count);
        end
        n_checks++;
        if (saw_write !== 1'b0 || lost_grant !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_hold: got write_seen=%b grant_lost=%b, required 0 0", saw_write, lost_grant);
        end
        finish_cycle();
        fifo_full = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_write_enable !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_resume%0d: got en=%b, required 1", c, fifo_write_enable);
            end
            finish_cycle();
        end
        req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (grant_valid !== 1'b0 || stall_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sat_end: got gv=%b stall=%h, required gv=0 stall=ffff", grant_valid, stall_count);
        end
        finish_cycle();
        check_drained("sat");
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wcnt[i] = 0;
            exp_cnt[i] = 0;
        end
        drive_data();
        test_reset();
        test_single_producer();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_reset_mid_burst();
        test_stall_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
